// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 receive definitions: data-type codes, header byte lanes and the
// packet controller state encoding.
package mipi_csi_pkg;

    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    localparam logic [5:0] DT_FS = 6'h00;
    localparam logic [5:0] DT_FE = 6'h01;
    localparam logic [5:0] DT_LS = 6'h02;
    localparam logic [5:0] DT_LE = 6'h03;

    // First header word is {WC_L, DI}, second is {ECC, WC_H}.
    localparam int unsigned HDR_DI_LSB  = 0;
    localparam int unsigned HDR_WCL_LSB = 8;
    localparam int unsigned HDR_WCH_LSB = 0;
    localparam int unsigned HDR_ECC_LSB = 8;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StHdr1,
        StPay,
        StCrc,
        StFlush
    } state_e;

endpackage

// File: rtl/mipi_csi_rx_packet_ctrl.sv
// Arms the per-lane byte aligner for each HS burst and parses its aligned words
// into a CSI-2 header plus byte-enabled payload stream.
module mipi_csi_rx_packet_ctrl
    import mipi_csi_pkg::*;
#(
    parameter int unsigned MIPI_GEAR    = 16,
    parameter int unsigned SYNC_TIMEOUT = 64,
    parameter int unsigned RESET_HOLD   = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 hs_active_i,
    input  logic [MIPI_GEAR-1:0] aligned_i,
    input  logic                 aligned_valid_i,
    output logic                 aligner_reset_o,
    output logic                 pkt_start_o,
    output logic [5:0]           data_type_o,
    output logic [1:0]           vc_o,
    output logic [15:0]          word_count_o,
    output logic                 long_pkt_o,
    output logic [MIPI_GEAR-1:0] payload_o,
    output logic [1:0]           payload_be_o,
    output logic                 payload_valid_o,
    output logic                 payload_last_o,
    output logic                 pkt_done_o,
    output logic                 err_sync_o,
    output logic                 err_trunc_o
);

    if (MIPI_GEAR != 16) begin : g_gear_check
        $error("mipi_csi_rx_packet_ctrl: only MIPI_GEAR = 16 is supported");
    end

    localparam int unsigned TW = $clog2(SYNC_TIMEOUT + 1);
    localparam int unsigned HW = $clog2(RESET_HOLD + 1);

    state_e        state_q;
    logic [TW-1:0] tmo_q;
    logic [HW-1:0] hold_q;
    logic [15:0]   rem_q;
    logic [7:0]    di_q;
    logic [7:0]    wc_l_q;
    logic          short_done_q;

    logic [15:0] hdr_wc;
    logic        hdr_long;
    logic        in_pkt;

    assign hdr_wc   = {aligned_i[HDR_WCH_LSB +: 8], wc_l_q};
    assign hdr_long = (di_q[5:0] >= DT_LONG_MIN);
    assign in_pkt   = (state_q == StHdr1) || (state_q == StPay) || (state_q == StCrc);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q         <= StIdle;
            tmo_q           <= '0;
            hold_q          <= '0;
            rem_q           <= '0;
            di_q            <= '0;
            wc_l_q          <= '0;
            short_done_q    <= 1'b0;
            aligner_reset_o <= 1'b1;
            pkt_start_o     <= 1'b0;
            data_type_o     <= '0;
            vc_o            <= '0;
            word_count_o    <= '0;
            long_pkt_o      <= 1'b0;
            payload_o       <= '0;
            payload_be_o    <= '0;
            payload_valid_o <= 1'b0;
            payload_last_o  <= 1'b0;
            pkt_done_o      <= 1'b0;
            err_sync_o      <= 1'b0;
            err_trunc_o     <= 1'b0;
        end else begin
            pkt_start_o     <= 1'b0;
            payload_valid_o <= 1'b0;
            payload_last_o  <= 1'b0;
            pkt_done_o      <= 1'b0;
            err_sync_o      <= 1'b0;
            err_trunc_o     <= 1'b0;

            // Losing HS inside a packet beats any word presented in the same cycle.
            if (in_pkt && !hs_active_i) begin
                err_trunc_o     <= 1'b1;
                aligner_reset_o <= 1'b1;
                state_q         <= StFlush;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        aligner_reset_o <= 1'b1;
                        if (hold_q != '0) begin
                            hold_q <= hold_q - HW'(1);
                        end else if (hs_active_i) begin
                            aligner_reset_o <= 1'b0;
                            tmo_q           <= '0;
                            state_q         <= StSync;
                        end
                    end
                    StSync: begin
                        if (!hs_active_i) begin
                            aligner_reset_o <= 1'b1;
                            state_q         <= StFlush;
                        end else if (aligned_valid_i) begin
                            di_q    <= aligned_i[HDR_DI_LSB +: 8];
                            wc_l_q  <= aligned_i[HDR_WCL_LSB +: 8];
                            state_q <= StHdr1;
                        end else if (tmo_q == TW'(SYNC_TIMEOUT - 1)) begin
                            err_sync_o      <= 1'b1;
                            aligner_reset_o <= 1'b1;
                            state_q         <= StFlush;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    StHdr1: begin
                        if (aligned_valid_i) begin
                            pkt_start_o  <= 1'b1;
                            data_type_o  <= di_q[5:0];
                            vc_o         <= di_q[7:6];
                            word_count_o <= hdr_wc;
                            long_pkt_o   <= hdr_long;
                            if (!hdr_long || hdr_wc == 16'd0) begin
                                // Completion is reported from FLUSH, one cycle after the header.
                                short_done_q    <= 1'b1;
                                aligner_reset_o <= 1'b1;
                                state_q         <= StFlush;
                            end else begin
                                rem_q   <= hdr_wc;
                                state_q <= StPay;
                            end
                        end
                    end
                    StPay: begin
                        if (aligned_valid_i) begin
                            payload_o       <= aligned_i;
                            payload_valid_o <= 1'b1;
                            if (rem_q >= 16'd2) begin
                                payload_be_o   <= 2'b11;
                                rem_q          <= rem_q - 16'd2;
                                payload_last_o <= (rem_q == 16'd2);
                            end else begin
                                payload_be_o   <= 2'b01;
                                rem_q          <= 16'd0;
                                payload_last_o <= 1'b1;
                            end
                            // Even WC leaves a whole CRC word; odd WC leaves CRC high in one more word.
                            if (rem_q <= 16'd2) begin
                                state_q <= StCrc;
                            end
                        end
                    end
                    StCrc: begin
                        if (aligned_valid_i) begin
                            pkt_done_o      <= 1'b1;
                            aligner_reset_o <= 1'b1;
                            state_q         <= StFlush;
                        end
                    end
                    StFlush: begin
                        aligner_reset_o <= 1'b1;
                        hold_q          <= HW'(RESET_HOLD);
                        pkt_done_o      <= short_done_q;
                        short_done_q    <= 1'b0;
                        state_q         <= StIdle;
                    end
                    default: begin
                        aligner_reset_o <= 1'b1;
                        state_q         <= StFlush;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mipi_csi_rx_packet_ctrl.sv
// Scoreboard bench for mipi_csi_rx_packet_ctrl: payload expectations are queued
// as words are driven and popped by a monitor as payload_valid_o appears.
module tb_mipi_csi_rx_packet_ctrl;
    import mipi_csi_pkg::*;

    localparam int unsigned SyncTimeout = 64;
    localparam int unsigned ResetHold   = 4;

    logic        clk_i;
    logic        reset_n_i;
    logic        hs_active_i;
    logic [15:0] aligned_i;
    logic        aligned_valid_i;
    logic        aligner_reset_o;
    logic        pkt_start_o;
    logic [5:0]  data_type_o;
    logic [1:0]  vc_o;
    logic [15:0] word_count_o;
    logic        long_pkt_o;
    logic [15:0] payload_o;
    logic [1:0]  payload_be_o;
    logic        payload_valid_o;
    logic        payload_last_o;
    logic        pkt_done_o;
    logic        err_sync_o;
    logic        err_trunc_o;

    mipi_csi_rx_packet_ctrl #(
        .MIPI_GEAR    (16),
        .SYNC_TIMEOUT (SyncTimeout),
        .RESET_HOLD   (ResetHold)
    ) u_dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .hs_active_i     (hs_active_i),
        .aligned_i       (aligned_i),
        .aligned_valid_i (aligned_valid_i),
        .aligner_reset_o (aligner_reset_o),
        .pkt_start_o     (pkt_start_o),
        .data_type_o     (data_type_o),
        .vc_o            (vc_o),
        .word_count_o    (word_count_o),
        .long_pkt_o      (long_pkt_o),
        .payload_o       (payload_o),
        .payload_be_o    (payload_be_o),
        .payload_valid_o (payload_valid_o),
        .payload_last_o  (payload_last_o),
        .pkt_done_o      (pkt_done_o),
        .err_sync_o      (err_sync_o),
        .err_trunc_o     (err_trunc_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_start = 0, n_done = 0, n_sync = 0, n_trunc = 0, n_last = 0;

    // Expected {payload, be, last}
    logic [18:0] exp_q[$];
    logic [18:0] exp_e;

    always @(negedge clk_i) begin
        if (reset_n_i) begin
            if (pkt_start_o) n_start++;
            if (pkt_done_o)  n_done++;
            if (err_sync_o)  n_sync++;
            if (err_trunc_o) n_trunc++;
            if (payload_valid_o && payload_last_o) n_last++;
            if (payload_valid_o) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL payload_unexpected got=%h/%b/%b want=none",
                             payload_o, payload_be_o, payload_last_o);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({payload_o, payload_be_o, payload_last_o} !== exp_e) begin
                        tests_failed++;
                        $display("FAIL payload_word got=%h/%b/%b want=%h/%b/%b",
                                 payload_o, payload_be_o, payload_last_o,
                                 exp_e[18:3], exp_e[2:1], exp_e[0]);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_release();
        int cnt;
        cnt = 0;
        hs_active_i = 1'b1;
        while (aligner_reset_o && cnt < 40) begin
            tick();
            cnt++;
        end
        tests_run++;
        if (aligner_reset_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_timeout aligner_reset=%b after %0d cycles want=0",
                     aligner_reset_o, cnt);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        aligned_i       = w;
        aligned_valid_i = 1'b1;
        tick();
        aligned_valid_i = 1'b0;
    endtask

    task automatic end_burst();
        hs_active_i     = 1'b0;
        aligned_valid_i = 1'b0;
        idle_cycles(10);
    endtask

    task automatic send_header(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
        logic [15:0] w;
        w = '0;
        w[HDR_DI_LSB +: 8]  = di;
        w[HDR_WCL_LSB +: 8] = wc[7:0];
        send_word(w);
        w[HDR_WCH_LSB +: 8] = wc[15:8];
        w[HDR_ECC_LSB +: 8] = ecc;
        send_word(w);
    endtask

    // Drives up to max_words payload words and queues what each should produce.
    task automatic drive_payload(input logic [15:0] wc, input int max_words, input bit gap);
        int          left;
        int          k;
        logic [15:0] w;
        logic [1:0]  be;
        left = int'(wc);
        k    = 0;
        while (left > 0 && k < max_words) begin
            w = 16'($urandom);
            if (left >= 2) begin
                be = 2'b11;
                left -= 2;
            end else begin
                be = 2'b01;
                left = 0;
            end
            exp_q.push_back({w, be, (left == 0)});
            send_word(w);
            if (gap && k == 0) tick();
            k++;
        end
    endtask

    task automatic test_reset();
        reset_n_i       = 1'b0;
        hs_active_i     = 1'b0;
        aligned_i       = '0;
        aligned_valid_i = 1'b0;
        idle_cycles(3);
        tests_run++;
        if ({aligner_reset_o, pkt_start_o, data_type_o, vc_o, word_count_o, long_pkt_o,
             payload_o, payload_be_o, payload_valid_o, payload_last_o, pkt_done_o,
             err_sync_o, err_trunc_o} !== {1'b1, 49'd0}) begin
            tests_failed++;
            $display("FAIL reset_values aligner_reset=%b start=%b dt=%h wc=%h valid=%b want ar=1 rest=0",
                     aligner_reset_o, pkt_start_o, data_type_o, word_count_o, payload_valid_o);
        end
        #3 reset_n_i = 1'b1;
        idle_cycles(4);
        tests_run++;
        if (aligner_reset_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_no_hs aligner_reset=%b want=1", aligner_reset_o);
        end
    endtask

    task automatic test_short_fs();
        int d0, cnt;
        d0 = n_done;
        wait_release();
        send_header(8'h00, 16'h0000, 8'hAB);
        tests_run++;
        if (pkt_start_o !== 1'b1 || data_type_o !== DT_FS || long_pkt_o !== 1'b0 ||
            word_count_o !== 16'h0000 || pkt_done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_hdr start=%b dt=%h long=%b wc=%h done=%b want 1/00/0/0000/0",
                     pkt_start_o, data_type_o, long_pkt_o, word_count_o, pkt_done_o);
        end
        tick();
        tests_run++;
        if (pkt_done_o !== 1'b1 || aligner_reset_o !== 1'b1 || pkt_start_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_done done=%b ar=%b start=%b want 1/1/0",
                     pkt_done_o, aligner_reset_o, pkt_start_o);
        end
        cnt = 0;
        while (aligner_reset_o && cnt < 40) begin
            tick();
            cnt++;
        end
        tests_run++;
        if (cnt < ResetHold || aligner_reset_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_rearm hold=%0d ar=%b want >=%0d then 0", cnt, aligner_reset_o,
                     ResetHold);
        end
        end_burst();
        tests_run++;
        if (n_done - d0 !== 1) begin
            tests_failed++;
            $display("FAIL short_done_count got=%0d want=1", n_done - d0);
        end
    endtask

    task automatic test_long_raw10();
        int d0;
        d0 = n_done;
        wait_release();
        send_header(8'h2B, 16'd6, 8'h5A);
        tests_run++;
        if (pkt_start_o !== 1'b1 || data_type_o !== 6'h2B || vc_o !== 2'd0 ||
            word_count_o !== 16'd6 || long_pkt_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw10_hdr start=%b dt=%h vc=%0d wc=%0d long=%b want 1/2b/0/6/1",
                     pkt_start_o, data_type_o, vc_o, word_count_o, long_pkt_o);
        end
        drive_payload(16'd6, 100, 1'b1);
        tests_run++;
        if (payload_valid_o !== 1'b1 || payload_last_o !== 1'b1 || payload_be_o !== 2'b11 ||
            n_done != d0) begin
            tests_failed++;
            $display("FAIL raw10_last valid=%b last=%b be=%b early_done=%0d want 1/1/11/0",
                     payload_valid_o, payload_last_o, payload_be_o, n_done - d0);
        end
        send_word(16'hC3C3);
        tests_run++;
        if (pkt_done_o !== 1'b1 || aligner_reset_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw10_done done=%b ar=%b want 1/1", pkt_done_o, aligner_reset_o);
        end
        end_burst();
    endtask

    task automatic test_odd_wc();
        int l0;
        l0 = n_last;
        wait_release();
        send_header(8'hAA, 16'd5, 8'h11);
        tests_run++;
        if (data_type_o !== 6'h2A || vc_o !== 2'd2 || word_count_o !== 16'd5) begin
            tests_failed++;
            $display("FAIL odd_hdr dt=%h vc=%0d wc=%0d want 2a/2/5", data_type_o, vc_o, word_count_o);
        end
        drive_payload(16'd5, 100, 1'b0);
        tests_run++;
        if (payload_be_o !== 2'b01 || payload_last_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL odd_last be=%b last=%b want 01/1", payload_be_o, payload_last_o);
        end
        send_word(16'h7E7E);
        tests_run++;
        if (pkt_done_o !== 1'b1 || n_last - l0 !== 1) begin
            tests_failed++;
            $display("FAIL odd_done done=%b lasts=%0d want 1/1", pkt_done_o, n_last - l0);
        end
        end_burst();
    endtask

    task automatic test_sync_timeout();
        int s0, cnt;
        s0 = n_sync;
        wait_release();
        cnt = 0;
        while (!err_sync_o && cnt < 200) begin
            tick();
            cnt++;
        end
        tests_run++;
        if (cnt != SyncTimeout || aligner_reset_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL sync_timeout cycles=%0d ar=%b want %0d/1", cnt, aligner_reset_o,
                     SyncTimeout);
        end
        cnt = 0;
        while (aligner_reset_o && cnt < 40) begin
            tick();
            cnt++;
        end
        tests_run++;
        if (cnt < ResetHold || aligner_reset_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL sync_rearm hold=%0d ar=%b want >=%0d then 0", cnt, aligner_reset_o,
                     ResetHold);
        end
        end_burst();
        tests_run++;
        if (n_sync - s0 !== 1) begin
            tests_failed++;
            $display("FAIL sync_err_count got=%0d want=1", n_sync - s0);
        end
    endtask

    task automatic test_truncation();
        int d0, l0, t0;
        d0 = n_done;
        l0 = n_last;
        t0 = n_trunc;
        wait_release();
        send_header(8'h2B, 16'd8, 8'h22);
        drive_payload(16'd8, 2, 1'b0);
        aligned_i       = 16'hDEAD;
        aligned_valid_i = 1'b1;
        hs_active_i     = 1'b0;
        tick();
        aligned_valid_i = 1'b0;
        tests_run++;
        if (err_trunc_o !== 1'b1 || payload_valid_o !== 1'b0 || payload_last_o !== 1'b0 ||
            aligner_reset_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL trunc_pulse trunc=%b valid=%b last=%b ar=%b want 1/0/0/1",
                     err_trunc_o, payload_valid_o, payload_last_o, aligner_reset_o);
        end
        end_burst();
        tests_run++;
        if (n_done != d0 || n_last != l0 || n_trunc - t0 !== 1) begin
            tests_failed++;
            $display("FAIL trunc_counts done=%0d last=%0d trunc=%0d want 0/0/1",
                     n_done - d0, n_last - l0, n_trunc - t0);
        end
    endtask

    task automatic test_max_wc();
        int l0;
        l0 = n_last;
        wait_release();
        send_header(8'h2B, 16'hFFFF, 8'h33);
        tests_run++;
        if (word_count_o !== 16'hFFFF || long_pkt_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL maxwc_hdr wc=%h long=%b want ffff/1", word_count_o, long_pkt_o);
        end
        drive_payload(16'hFFFF, 40000, 1'b0);
        send_word(16'h0F0F);
        tests_run++;
        if (pkt_done_o !== 1'b1 || n_last - l0 !== 1) begin
            tests_failed++;
            $display("FAIL maxwc_done done=%b lasts=%0d want 1/1", pkt_done_o, n_last - l0);
        end
        end_burst();
    endtask

    task automatic test_async_reset();
        int d0, t0;
        d0 = n_done;
        t0 = n_trunc;
        wait_release();
        send_header(8'h2B, 16'd8, 8'h44);
        drive_payload(16'd8, 1, 1'b0);
        @(negedge clk_i);
        #2 reset_n_i = 1'b0;
        #1;
        tests_run++;
        if ({aligner_reset_o, pkt_start_o, data_type_o, vc_o, word_count_o, long_pkt_o,
             payload_o, payload_be_o, payload_valid_o, payload_last_o, pkt_done_o,
             err_sync_o, err_trunc_o} !== {1'b1, 49'd0}) begin
            tests_failed++;
            $display("FAIL async_reset ar=%b dt=%h wc=%h long=%b payload=%h want ar=1 rest=0",
                     aligner_reset_o, data_type_o, word_count_o, long_pkt_o, payload_o);
        end
        hs_active_i = 1'b0;
        idle_cycles(3);
        #2 reset_n_i = 1'b1;
        idle_cycles(3);
        tests_run++;
        if (n_done != d0 || n_trunc != t0) begin
            tests_failed++;
            $display("FAIL async_no_pulse done=%0d trunc=%0d want 0/0", n_done - d0, n_trunc - t0);
        end
        wait_release();
        send_header(8'h42, 16'd7, 8'h55);
        tests_run++;
        if (pkt_start_o !== 1'b1 || data_type_o !== DT_LS || vc_o !== 2'd1 ||
            word_count_o !== 16'd7 || long_pkt_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_hdr start=%b dt=%h vc=%0d wc=%0d long=%b want 1/02/1/7/0",
                     pkt_start_o, data_type_o, vc_o, word_count_o, long_pkt_o);
        end
        tick();
        tests_run++;
        if (pkt_done_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_done done=%b want=1", pkt_done_o);
        end
        end_burst();
    endtask

    initial begin
        test_reset();
        test_short_fs();
        test_long_raw10();
        test_odd_wc();
        test_sync_timeout();
        test_truncation();
        test_max_wc();
        test_async_reset();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
